// File: rtl/ysyx_23060077_riscv_axil_sram.sv
// ysyx_23060077_riscv_axil_sram
// AXI4-Lite slave memory that terminates the core's AXI-Lite master.
// It serves instruction-side and LSU loads/stores from an internal word array.
// The read and write channels are independent FSMs. Their response latency is
// programmable and can optionally be stretched by an LFSR, which exercises the
// LSU stall path.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   araddr/arvalid/arready     read address channel
//   rdata/rresp/rvalid/rready  read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready     write address channel
//   wdata/wstrb/wvalid/wready  write data channel, lane-aligned data
//   bresp/bvalid/bready        write response channel (00 OKAY, 10 SLVERR)
module ysyx_23060077_riscv_axil_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           WR_LATENCY = 2,
  parameter bit                    RAND_EN    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT  = CNT_W'(WR_LATENCY);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic                  init_done_q;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [CNT_W-1:0]      rand_add;

  logic [1:0]            r_state_q, r_state_d;
  logic [CNT_W-1:0]      r_cnt_q, r_cnt_d, r_load;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, rd_sel_addr, rd_off;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, r_sample, rd_in;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic [1:0]            w_state_q, w_state_d;
  logic [CNT_W-1:0]      w_cnt_q, w_cnt_d, w_load;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, wa_eff, wr_sel_addr, wr_off;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wd_eff, wr_data_c;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d, ws_eff, wr_strb_c;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs, w_hs, w_commit, wr_in;
  logic [DEPTH_LOG2-1:0] wr_idx;

  logic                  unused_lsbs;

  // Fibonacci LFSR, taps 8,6,5,4; only its low two bits stretch latency.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign rand_add = RAND_EN ? {{(CNT_W-2){1'b0}}, lfsr_q[1:0]} : '0;
  assign r_load   = RD_LAT + rand_add;
  assign w_load   = WR_LAT + rand_add;

  assign arready = init_done_q && (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = init_done_q && (w_state_q == W_IDLE) && !aw_got_q;
  assign wready  = init_done_q && (w_state_q == W_IDLE) && !w_got_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Read decode: with zero latency the word is sampled in the accept cycle,
  // so the incoming address is used while idle.
  assign rd_sel_addr = (r_state_q == R_IDLE) ? araddr : r_addr_q;
  assign rd_off      = rd_sel_addr - BASE_ADDR;
  assign rd_in       = (rd_sel_addr >= BASE_ADDR) && (rd_off[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign rd_idx      = rd_off[DEPTH_LOG2+1:2];

  // A beat captured earlier takes priority over the bus for the commit.
  assign wa_eff      = aw_got_q ? awaddr_q : awaddr;
  assign wd_eff      = w_got_q  ? wdata_q  : wdata;
  assign ws_eff      = w_got_q  ? wstrb_q  : wstrb;
  assign wr_sel_addr = (w_state_q == W_IDLE) ? wa_eff : awaddr_q;
  assign wr_data_c   = (w_state_q == W_IDLE) ? wd_eff : wdata_q;
  assign wr_strb_c   = (w_state_q == W_IDLE) ? ws_eff : wstrb_q;
  assign wr_off      = wr_sel_addr - BASE_ADDR;
  assign wr_in       = (wr_sel_addr >= BASE_ADDR) && (wr_off[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign wr_idx      = wr_off[DEPTH_LOG2+1:2];

  assign unused_lsbs = ^{rd_off[1:0], wr_off[1:0]};

  // Read channel next state. The counter holds remaining wait cycles minus
  // one, so rvalid rises exactly load+1 cycles after the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_sample  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_addr_d = araddr;
          if (r_load == '0) begin
            r_sample  = 1'b1;
            r_state_d = R_RESP;
          end else begin
            r_cnt_d   = r_load - CNT_ONE;
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          r_sample  = 1'b1;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - CNT_ONE;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    // Array read sees pre-edge contents, giving read-before-write on collision.
    if (r_sample) begin
      rdata_d = rd_in ? mem_q[rd_idx] : '0;
      rresp_d = rd_in ? 2'b00 : 2'b10;
    end
  end

  // Write channel next state. AW and W are captured independently; the
  // transaction starts once both are held, including the same-cycle case.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          awaddr_d = wa_eff;
          wdata_d  = wd_eff;
          wstrb_d  = ws_eff;
          if (w_load == '0) begin
            w_commit  = 1'b1;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_load - CNT_ONE;
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          w_commit  = 1'b1;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - CNT_ONE;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_commit) bresp_d = wr_in ? 2'b00 : 2'b10;
  end

  // Control registers; init_done keeps every ready low for the first cycle
  // after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      lfsr_q      <= 8'hA5;
      r_state_q   <= R_IDLE;
      r_cnt_q     <= '0;
      r_addr_q    <= '0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      w_state_q   <= W_IDLE;
      w_cnt_q     <= '0;
      aw_got_q    <= 1'b0;
      w_got_q     <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= 2'b00;
    end else begin
      init_done_q <= 1'b1;
      lfsr_q      <= lfsr_d;
      r_state_q   <= r_state_d;
      r_cnt_q     <= r_cnt_d;
      r_addr_q    <= r_addr_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      w_state_q   <= w_state_d;
      w_cnt_q     <= w_cnt_d;
      aw_got_q    <= aw_got_d;
      w_got_q     <= w_got_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
    end
  end

  // Storage array, not reset. A commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && wr_in) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb_c[i]) mem_q[wr_idx][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_riscv_axil_sram.sv
// Testbench for ysyx_23060077_riscv_axil_sram.
// Unit 0 runs with fixed latency 2. Unit 1 runs with the same latency plus
// LFSR-driven extra delay, checked against a scoreboard.
module tb_ysyx_23060077_riscv_axil_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0][31:0] araddr, awaddr, wdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       arvalid, rready, awvalid, wvalid, bready;
  wire  [1:0][31:0] rdata;
  wire  [1:0][1:0]  rresp, bresp;
  wire  [1:0]       arready, rvalid, awready, wready, bvalid;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_axil_sram #(.RD_LATENCY(2), .WR_LATENCY(2), .RAND_EN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_23060077_riscv_axil_sram #(.RD_LATENCY(2), .WR_LATENCY(2), .RAND_EN(1'b1)) dutRand (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  // Full write with AW and W in the same cycle; lat counts cycles from the
  // handshake to the first bvalid (capped at 50).
  task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp, output int lat);
    int n = 0;
    @(negedge clk);
    awaddr[u] = a; wdata[u] = d; wstrb[u] = s;
    awvalid[u] = 1'b1; wvalid[u] = 1'b1; bready[u] = 1'b1;
    while (!(awready[u] && wready[u]) && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid[u] = 1'b0; wvalid[u] = 1'b0;
    lat = 1;
    while (!bvalid[u] && lat < 50) begin @(negedge clk); lat++; end
    resp = bresp[u];
    @(negedge clk);
    bready[u] = 1'b0;
  endtask

  task automatic do_read(input int u, input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n = 0;
    @(negedge clk);
    araddr[u] = a; arvalid[u] = 1'b1; rready[u] = 1'b1;
    while (!arready[u] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid[u] = 1'b0;
    lat = 1;
    while (!rvalid[u] && lat < 50) begin @(negedge clk); lat++; end
    d = rdata[u]; resp = rresp[u];
    @(negedge clk);
    rready[u] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    assertions++;
    if ({arready[0], awready[0], wready[0], rvalid[0], bvalid[0], rresp[0], bresp[0], rdata[0]} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ar=%b aw=%b w=%b rv=%b bv=%b rdata=%h, expected all 0",
               arready[0], awready[0], wready[0], rvalid[0], bvalid[0], rdata[0]);
    end
    rst_n = 1'b1;
    assertions++;
    if ({arready[0], awready[0], wready[0]} !== 3'b000) begin
      failures++;
      $display("FAIL ready_first_cycle: got %b expected 000", {arready[0], awready[0], wready[0]});
    end
    @(negedge clk);
    assertions++;
    if ({arready[0], awready[0], wready[0]} !== 3'b111) begin
      failures++;
      $display("FAIL ready_second_cycle: got %b expected 111", {arready[0], awready[0], wready[0]});
    end
    assertions++;
    if ({rvalid[0], bvalid[0]} !== 2'b00) begin
      failures++;
      $display("FAIL valids_after_reset: got %b expected 00", {rvalid[0], bvalid[0]});
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] resp; int lat;
    do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
    assertions++;
    if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    assertions++;
    if (resp !== 2'b00) begin failures++; $display("FAIL wr_bresp: got %b expected 00", resp); end
    do_read(0, 32'h8000_0010, d, resp, lat);
    assertions++;
    if (lat !== 3) begin failures++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    assertions++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %h expected deadbeef", d); end
    assertions++;
    if (resp !== 2'b00) begin failures++; $display("FAIL rd_rresp: got %b expected 00", resp); end
  endtask

  task automatic test_split_strobe();
    logic [31:0] d; logic [1:0] resp; int lat;
    @(negedge clk);
    wdata[0] = 32'h0000_5500; wstrb[0] = 4'b0010; wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    wvalid[0] = 1'b0;
    assertions++;
    if ({wready[0], awready[0], bvalid[0]} !== 3'b010) begin
      failures++;
      $display("FAIL split_after_w: got wr/aw/bv=%b expected 010", {wready[0], awready[0], bvalid[0]});
    end
    @(negedge clk);
    assertions++;
    if ({wready[0], bvalid[0]} !== 2'b00) begin
      failures++;
      $display("FAIL split_w_held: got wr/bv=%b expected 00", {wready[0], bvalid[0]});
    end
    awaddr[0] = 32'h8000_0010; awvalid[0] = 1'b1;
    @(negedge clk);
    awvalid[0] = 1'b0;
    lat = 1;
    while (!bvalid[0] && lat < 50) begin @(negedge clk); lat++; end
    assertions++;
    if (lat !== 3) begin failures++; $display("FAIL split_latency: got %0d expected 3", lat); end
    assertions++;
    if (bresp[0] !== 2'b00) begin failures++; $display("FAIL split_bresp: got %b expected 00", bresp[0]); end
    @(negedge clk);
    bready[0] = 1'b0;
    assertions++;
    if ({bvalid[0], awready[0], wready[0]} !== 3'b011) begin
      failures++;
      $display("FAIL split_single_b: got bv/aw/wr=%b expected 011", {bvalid[0], awready[0], wready[0]});
    end
    do_read(0, 32'h8000_0010, d, resp, lat);
    assertions++;
    if (d !== 32'hDEAD_55EF) begin failures++; $display("FAIL split_readback: got %h expected dead55ef", d); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    assertions++;
    if (arready[0] !== 1'b1) begin failures++; $display("FAIL bp_idle_ready: got %b expected 1", arready[0]); end
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b0;
    @(negedge clk);
    arvalid[0] = 1'b0;
    while (!rvalid[0] && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if (rvalid[0] !== 1'b1) begin failures++; $display("FAIL bp_rvalid[%0d]: got %b expected 1", i, rvalid[0]); end
      assertions++;
      if (rdata[0] !== 32'hDEAD_55EF) begin failures++; $display("FAIL bp_rdata[%0d]: got %h expected dead55ef", i, rdata[0]); end
      assertions++;
      if (arready[0] !== 1'b0) begin failures++; $display("FAIL bp_arready[%0d]: got %b expected 0", i, arready[0]); end
      @(negedge clk);
    end
    rready[0] = 1'b1;
    @(negedge clk);
    rready[0] = 1'b0;
    assertions++;
    if ({rvalid[0], arready[0]} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release: got rv/ar=%b expected 01", {rvalid[0], arready[0]});
    end
  endtask

  task automatic test_error_collision();
    logic [31:0] d, dCol; logic [1:0] resp, respW; int lat, latW;
    do_write(0, 32'h8000_0000, 32'hCAFE_0000, 4'hF, resp, lat);
    do_read(0, 32'h0000_0000, d, resp, lat);
    assertions++;
    if (resp !== 2'b10) begin failures++; $display("FAIL oob_rresp: got %b expected 10", resp); end
    assertions++;
    if (d !== 32'h0) begin failures++; $display("FAIL oob_rdata: got %h expected 00000000", d); end
    do_read(0, 32'h8000_4000, d, resp, lat);
    assertions++;
    if (resp !== 2'b10) begin failures++; $display("FAIL oob_end_rresp: got %b expected 10", resp); end
    do_write(0, 32'h8001_0000, 32'h1234_5678, 4'hF, resp, lat);
    assertions++;
    if (resp !== 2'b10) begin failures++; $display("FAIL oob_bresp: got %b expected 10", resp); end
    do_read(0, 32'h8000_0000, d, resp, lat);
    assertions++;
    if (d !== 32'hCAFE_0000) begin failures++; $display("FAIL oob_no_alias: got %h expected cafe0000", d); end
    do_write(0, 32'h8000_3FFC, 32'h0F0F_0F0F, 4'hF, resp, lat);
    do_read(0, 32'h8000_3FFC, d, resp, lat);
    assertions++;
    if ({resp, d} !== {2'b00, 32'h0F0F_0F0F}) begin
      failures++;
      $display("FAIL last_word: got resp=%b data=%h expected 00/0f0f0f0f", resp, d);
    end
    do_write(0, 32'h8000_0020, 32'h1111_1111, 4'hF, resp, lat);
    fork
      do_read(0, 32'h8000_0020, dCol, resp, lat);
      do_write(0, 32'h8000_0020, 32'h2222_2222, 4'hF, respW, latW);
    join
    assertions++;
    if (lat !== latW) begin failures++; $display("FAIL col_same_cycle: rd lat %0d wr lat %0d expected equal", lat, latW); end
    assertions++;
    if (dCol !== 32'h1111_1111) begin failures++; $display("FAIL col_old_data: got %h expected 11111111", dCol); end
    do_read(0, 32'h8000_0020, d, resp, lat);
    assertions++;
    if (d !== 32'h2222_2222) begin failures++; $display("FAIL col_new_data: got %h expected 22222222", d); end
  endtask

  task automatic test_midop_reset();
    logic [31:0] d; logic [1:0] resp; int lat;
    do_write(0, 32'h8000_0030, 32'hAAAA_0000, 4'hF, resp, lat);
    @(negedge clk);
    araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1; rready[0] = 1'b1;
    @(negedge clk);
    arvalid[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    assertions++;
    if ({rvalid[0], arready[0]} !== 2'b00) begin
      failures++;
      $display("FAIL rd_reset_edge: got rv/ar=%b expected 00", {rvalid[0], arready[0]});
    end
    @(negedge clk);
    assertions++;
    if (arready[0] !== 1'b1) begin failures++; $display("FAIL rd_reset_idle: got %b expected 1", arready[0]); end
    repeat (4) @(negedge clk);
    rready[0] = 1'b0;
    assertions++;
    if (rvalid[0] !== 1'b0) begin failures++; $display("FAIL rd_reset_dropped: got %b expected 0", rvalid[0]); end
    awaddr[0] = 32'h8000_0030; wdata[0] = 32'h5555_5555; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b1;
    @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    assertions++;
    if (bvalid[0] !== 1'b0) begin failures++; $display("FAIL wr_reset_edge: got %b expected 0", bvalid[0]); end
    @(negedge clk);
    assertions++;
    if ({awready[0], wready[0]} !== 2'b11) begin
      failures++;
      $display("FAIL wr_reset_idle: got %b expected 11", {awready[0], wready[0]});
    end
    repeat (4) @(negedge clk);
    bready[0] = 1'b0;
    assertions++;
    if (bvalid[0] !== 1'b0) begin failures++; $display("FAIL wr_reset_dropped: got %b expected 0", bvalid[0]); end
    do_read(0, 32'h8000_0030, d, resp, lat);
    assertions++;
    if (d !== 32'hAAAA_0000) begin failures++; $display("FAIL wr_reset_no_commit: got %h expected aaaa0000", d); end
  endtask

  task automatic test_random();
    logic [31:0] sb [16];
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    int lat, idx;
    int minLat = 99;
    int maxLat = 0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = $urandom;
      do_write(1, 32'h8000_0000 + 32'(4 * i), sb[i], 4'hF, resp, lat);
      assertions++;
      if (lat < 3 || lat > 6 || resp !== 2'b00) begin
        failures++;
        $display("FAIL rand_fill[%0d]: got lat=%0d resp=%b expected lat 3..6 resp 00", i, lat, resp);
      end
    end
    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(1, 32'h8000_0000 + 32'(4 * idx), d, s, resp, lat);
        for (int b = 0; b < 4; b++) if (s[b]) sb[idx][8*b +: 8] = d[8*b +: 8];
        assertions++;
        if (resp !== 2'b00) begin failures++; $display("FAIL rand_bresp[%0d]: got %b expected 00", n, resp); end
      end else begin
        do_read(1, 32'h8000_0000 + 32'(4 * idx), d, resp, lat);
        assertions++;
        if (d !== sb[idx]) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, d, sb[idx]); end
      end
      assertions++;
      if (lat < 3 || lat > 6) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 3..6", n, lat); end
      if (lat < minLat) minLat = lat;
      if (lat > maxLat) maxLat = lat;
    end
    assertions++;
    if (!(maxLat > minLat)) begin
      failures++;
      $display("FAIL rand_spread: got min=%0d max=%0d expected varying latency", minLat, maxLat);
    end
  endtask

  // Bounds the whole run so a stuck handshake can never hang the simulator.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
    test_reset();
    test_write_read();
    test_split_strobe();
    test_backpressure();
    test_error_collision();
    test_midop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_riscv_axil_sram.md
Name: ysyx_23060077_riscv_axil_sram

Overview:
AXI4-Lite slave memory that terminates the core's AXI-Lite master, downstream of the load/store unit. It serves instruction-side and LSU loads and stores from an internal word array. Read and write channels run as independent FSMs with programmable, optionally randomised response latency, so the LSU stall path (mem_stall) is exercised under variable delay.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8 = 4.
DEPTH_LOG2, 12, log2 of the word count; 4096 words (16 KiB).
BASE_ADDR, 32'h8000_0000, byte address of word 0.
RD_LATENCY, 2, minimum wait cycles between AR accept and rvalid.
WR_LATENCY, 2, minimum wait cycles between AW+W capture and bvalid.
RAND_EN, 0, 1 adds 0..3 extra cycles per transaction from the LFSR.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data, full aligned word
rresp  out  2  00 OKAY, 10 SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data, lane-aligned
wstrb  in  4  byte-lane enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset is synchronous on rst_n, clk only. While rst_n=0: all outputs 0, FSMs go to IDLE, capture flags clear, LFSR = 8'hA5. The init_done flag resets to 0 and sets to 1 one cycle after rst_n rises. All readies are gated by init_done. The memory array is not reset.
- Address decode: in range when BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2. Word index = (addr - BASE_ADDR)[DEPTH_LOG2+1:2]. addr[1:0] is ignored; upstream places bytes in the correct lanes.
- Read FSM states are R_IDLE, R_WAIT and R_RESP.
  - R_IDLE: arready=1. On arvalid&arready, latch the address, load cnt = RD_LATENCY + (RAND_EN ? lfsr[1:0] : 0), go to R_WAIT.
  - R_WAIT: cnt decrements each cycle. At cnt==0, sample the memory into the rdata register, set rresp, go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&rready, go to R_IDLE. No back-to-back accept: arready is 0 during R_WAIT and R_RESP.
  - With RAND_EN=0, rvalid first asserts exactly RD_LATENCY+1 cycles after the AR handshake cycle.
  - Out-of-range read: rresp=10, rdata=0.
- Write FSM states are W_IDLE, W_WAIT and W_RESP.
  - W_IDLE: awready = !aw_got, wready = !w_got. AW and W may handshake in the same or different cycles, in either order; each is captured into its own register and flag.
  - When both flags are set, or set in the same cycle, load cnt = WR_LATENCY (+lfsr[1:0] if RAND_EN) and go to W_WAIT. Flags clear on entry to W_WAIT.
  - W_WAIT: at cnt==0, commit the write. Only lanes with wstrb[i]=1 update; wstrb=0 writes nothing but still responds OKAY. Go to W_RESP.
  - W_RESP: bvalid=1 until bready, then go to W_IDLE.
  - Out-of-range write: no array update, bresp=10.
- Read and write collision: if the read sample and write commit hit the same word in the same cycle, the read returns the pre-write data (read-before-write). Otherwise the channels are fully independent.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle after reset, sampled at the handshake.
- Reset mid-transaction: the pending read or write is dropped with no array update. rvalid and bvalid are 0 on the cycle after the reset edge.
- Latency parameters are unsigned; 0 is legal. rvalid/bvalid then assert on the cycle after AR handshake / AW+W capture.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles, release -> arready/awready/wready are 0 in the first cycle, 1 in the next; all valids 0.
- Write then read: AW=0x8000_0010 with W=0xDEAD_BEEF, wstrb=4'hF in the same cycle; bready=1 -> bvalid 3 cycles after the handshake, bresp=00. Then read 0x8000_0010 -> rvalid 3 cycles after AR, rdata=0xDEAD_BEEF, rresp=00.
- Split AW/W and partial strobe: W=0x0000_5500, wstrb=4'b0010 two cycles before AW=0x8000_0010 -> wready drops after W capture, one bvalid; readback=0xDEAD_55EF.
- Backpressure: hold rready=0 for 5 cycles during R_RESP -> rvalid stays 1, rdata stable, arready stays 0; releasing rready for one cycle completes the transfer.
- Error and collision: read 0x0000_0000 -> rresp=10, rdata=0. Write 0x8001_0000 -> bresp=10, no array change. Same-cycle read sample and write commit to one word -> rdata holds the old value.
- Mid-op reset and random delay: assert rst_n=0 during R_WAIT -> no rvalid and the FSM is idle after reset. With RAND_EN=1, 200 random reads and writes -> every latency within [L+1, L+4] and data matches the scoreboard.
